hazard_scoreboard: RTL and testbench

Parametrised hazard and stall controller for the 5-stage RV32 pipeline with multi-cycle execution channels (divider, multiplier, long-latency memory). It combines the existing single-cycle interlocks (load-use, branch/JALR operand-not-ready, taken-branch redirect, EX busy freeze) with a register scoreboard and per-channel busy tracking. It sits beside the ID stage and drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB register controls.

---
 rtl/hazard_scoreboard.sv | 173 +++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard and stall controller for the 5-stage RV32 pipeline: single-cycle interlocks
// plus a register scoreboard and busy tracking for multi-cycle execution channels.
module hazard_scoreboard #(
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned STALL_LIMIT = 200,
    localparam int unsigned NREG       = 2 ** REG_AW,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [REG_AW-1:0] i_rs1,
    input  logic [REG_AW-1:0] i_rs2,
    input  logic [REG_AW-1:0] i_id_rd,
    input  logic              i_id_valid,
    input  logic              i_id_long,
    input  logic [CH_W-1:0]   i_id_ch,
    input  logic              i_id_branch,
    input  logic              i_id_jalr,
    input  logic              i_id_jump,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic              i_ex_regwrite,
    input  logic              i_ex_memread,
    input  logic [REG_AW-1:0] i_mem_rd,
    input  logic              i_mem_memread,
    input  logic              i_ex_br_taken,
    input  logic              i_ex_busy,
    input  logic              i_done_valid,
    input  logic [CH_W-1:0]   i_done_ch,
    input  logic [REG_AW-1:0] i_done_rd,
    output logic              o_pc_write,
    output logic              o_ifid_write,
    output logic              o_flush,
    output logic              o_kill,
    output logic              o_idex_write,
    output logic              o_exmem_write,
    output logic              o_memwb_write,
    output logic [NREG-1:0]   o_pending,
    output logic [NUM_CH-1:0] o_ch_busy,
    output logic [CNT_W-1:0]  o_stall_cnt,
    output logic              o_stall_alarm
);

    logic [NREG-1:0]   pending_q;
    logic [NREG-1:0]   pending_d;
    logic [NREG-1:0]   pend_eff;
    logic [NREG-1:0]   done_rd_oh;
    logic [NREG-1:0]   issue_rd_oh;
    logic [NUM_CH-1:0] busy_q;
    logic [NUM_CH-1:0] busy_d;
    logic [NUM_CH-1:0] busy_eff;
    logic [NUM_CH-1:0] done_ch_oh;
    logic [NUM_CH-1:0] issue_ch_oh;

    logic ex_prod;
    logic ex_rs1_hit;
    logic ex_rs2_hit;
    logic mem_rs1_hit;
    logic mem_rs2_hit;
    logic load_use;
    logic branch_hz;
    logic jalr_hz;
    logic sb_raw;
    logic sb_waw;
    logic struct_hz;
    logic data_stall;
    logic redirect;
    logic issue;

    // Completion one-hots; applying them before the hazard checks gives the zero-latency bypass
    always_comb begin
        done_rd_oh = '0;
        done_ch_oh = '0;
        for (int unsigned r = 1; r < NREG; r++) begin
            done_rd_oh[r] = i_done_valid && (i_done_rd == REG_AW'(r));
        end
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            done_ch_oh[c] = i_done_valid && (i_done_ch == CH_W'(c));
        end
        pend_eff    = pending_q & ~done_rd_oh;
        pend_eff[0] = 1'b0;
        busy_eff    = busy_q & ~done_ch_oh;
    end

    // Interlock terms; x0 never creates a dependency
    always_comb begin
        ex_prod     = i_ex_regwrite | i_ex_memread;
        ex_rs1_hit  = (i_ex_rd != '0) && (i_ex_rd == i_rs1);
        ex_rs2_hit  = (i_ex_rd != '0) && (i_ex_rd == i_rs2);
        mem_rs1_hit = (i_mem_rd != '0) && (i_mem_rd == i_rs1);
        mem_rs2_hit = (i_mem_rd != '0) && (i_mem_rd == i_rs2);

        load_use  = i_ex_memread & (ex_rs1_hit | ex_rs2_hit);
        branch_hz = i_id_branch & ((ex_prod & (ex_rs1_hit | ex_rs2_hit)) |
                                   (i_mem_memread & (mem_rs1_hit | mem_rs2_hit)));
        jalr_hz   = i_id_jalr & ((ex_prod & ex_rs1_hit) | (i_mem_memread & mem_rs1_hit));
        sb_raw    = pend_eff[i_rs1] | pend_eff[i_rs2];
        sb_waw    = pend_eff[i_id_rd];

        struct_hz = 1'b0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (i_id_ch == CH_W'(c)) begin
                struct_hz = i_id_long & busy_eff[c];
            end
        end

        data_stall = i_id_valid &
                     (load_use | branch_hz | jalr_hz | sb_raw | sb_waw | struct_hz);
        redirect   = i_ex_br_taken | i_id_jump;
        issue      = i_id_valid & i_id_long & ~data_stall & ~redirect & ~i_ex_busy;
    end

    // Stage-register controls: data stall beats redirect beats EX freeze
    always_comb begin
        o_pc_write    = ~i_ex_busy;
        o_ifid_write  = ~i_ex_busy;
        o_flush       = 1'b0;
        o_kill        = 1'b0;
        o_idex_write  = ~i_ex_busy;
        o_exmem_write = ~i_ex_busy;
        o_memwb_write = ~i_ex_busy;
        if (data_stall) begin
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
            o_flush      = 1'b1;
        end else if (redirect) begin
            o_pc_write   = 1'b1;
            o_ifid_write = 1'b1;
            o_flush      = 1'b1;
            o_kill       = 1'b1;
        end
    end

    // Scoreboard next state: an issue set overrides a same-cycle completion clear
    always_comb begin
        issue_rd_oh = '0;
        issue_ch_oh = '0;
        for (int unsigned r = 1; r < NREG; r++) begin
            issue_rd_oh[r] = issue && (i_id_rd == REG_AW'(r));
        end
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            issue_ch_oh[c] = issue && (i_id_ch == CH_W'(c));
        end
        pending_d    = (pending_q & ~done_rd_oh) | issue_rd_oh;
        pending_d[0] = 1'b0;
        busy_d       = (busy_q & ~done_ch_oh) | issue_ch_oh;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pending_q     <= '0;
            busy_q        <= '0;
            o_stall_cnt   <= '0;
            o_stall_alarm <= 1'b0;
        end else begin
            pending_q <= pending_d;
            busy_q    <= busy_d;
            if (!data_stall) begin
                o_stall_cnt <= '0;
            end else if (o_stall_cnt != '1) begin
                o_stall_cnt <= o_stall_cnt + CNT_W'(1);
            end
            if (o_stall_cnt >= CNT_W'(STALL_LIMIT)) begin
                o_stall_alarm <= 1'b1;
            end
        end
    end

    assign o_pending = pending_q;
    assign o_ch_busy = busy_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed scenarios then randomized traffic,
// checked against a register/channel reference model kept in plain arrays.
module tb_hazard_scoreboard;

    localparam int unsigned REG_AW      = 5;
    localparam int unsigned NUM_CH      = 2;
    localparam int unsigned CNT_W       = 3;
    localparam int unsigned STALL_LIMIT = 4;
    localparam int unsigned NREG        = 32;
    localparam int          CNT_MAX     = 7;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [REG_AW-1:0] rs1, rs2, id_rd, ex_rd, mem_rd, done_rd;
    logic              id_valid, id_long, id_branch, id_jalr, id_jump;
    logic [0:0]        id_ch, done_ch;
    logic              ex_regwrite, ex_memread, mem_memread, ex_br_taken, ex_busy, done_valid;
    logic              pc_write, ifid_write, flush, kill, idex_write, exmem_write, memwb_write;
    logic [NREG-1:0]   pending;
    logic [NUM_CH-1:0] ch_busy;
    logic [CNT_W-1:0]  stall_cnt;
    logic              stall_alarm;

    hazard_scoreboard #(
        .REG_AW(REG_AW), .NUM_CH(NUM_CH), .CNT_W(CNT_W), .STALL_LIMIT(STALL_LIMIT)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rs1(rs1), .i_rs2(rs2), .i_id_rd(id_rd),
        .i_id_valid(id_valid), .i_id_long(id_long), .i_id_ch(id_ch),
        .i_id_branch(id_branch), .i_id_jalr(id_jalr), .i_id_jump(id_jump),
        .i_ex_rd(ex_rd), .i_ex_regwrite(ex_regwrite), .i_ex_memread(ex_memread),
        .i_mem_rd(mem_rd), .i_mem_memread(mem_memread),
        .i_ex_br_taken(ex_br_taken), .i_ex_busy(ex_busy),
        .i_done_valid(done_valid), .i_done_ch(done_ch), .i_done_rd(done_rd),
        .o_pc_write(pc_write), .o_ifid_write(ifid_write),
        .o_flush(flush), .o_kill(kill),
        .o_idex_write(idex_write), .o_exmem_write(exmem_write), .o_memwb_write(memwb_write),
        .o_pending(pending), .o_ch_busy(ch_busy),
        .o_stall_cnt(stall_cnt), .o_stall_alarm(stall_alarm)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        pc_write;
        bit        ifid_write;
        bit        flush;
        bit        kill;
        bit        pipe_write;
        bit [31:0] pending;
        bit [1:0]  ch_busy;
        bit [2:0]  cnt;
        bit        alarm;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    bit m_pend[NREG];
    bit m_busy[NUM_CH];
    int m_cnt;
    bit m_alarm;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_src(input int r);
        return r != 0 && (r == int'(rs1) || r == int'(rs2));
    endfunction

    function automatic bit peff(input int r);
        return r != 0 && m_pend[r] && !(done_valid && int'(done_rd) == r);
    endfunction

    function automatic bit beff(input int c);
        return m_busy[c] && !(done_valid && int'(done_ch) == c);
    endfunction

    task automatic model_reset();
        foreach (m_pend[r]) m_pend[r] = 1'b0;
        foreach (m_busy[c]) m_busy[c] = 1'b0;
        m_cnt   = 0;
        m_alarm = 1'b0;
    endtask

    // Apply the hazard rules to the current inputs, queue the expectation, advance the model
    task automatic model_push();
        exp_t e;
        bit ex_prod, lu, br, jr, raw, waw, st, ds, redir, issue;
        ex_prod = ex_regwrite || ex_memread;
        lu  = ex_memread && is_src(int'(ex_rd));
        br  = id_branch && ((ex_prod && is_src(int'(ex_rd))) ||
                            (mem_memread && is_src(int'(mem_rd))));
        jr  = id_jalr && ((ex_prod && ex_rd != 0 && ex_rd == rs1) ||
                          (mem_memread && mem_rd != 0 && mem_rd == rs1));
        raw = peff(int'(rs1)) || peff(int'(rs2));
        waw = peff(int'(id_rd));
        st  = id_long && beff(int'(id_ch));
        ds  = id_valid && (lu || br || jr || raw || waw || st);
        redir = ex_br_taken || id_jump;
        if (ds) begin
            e.pc_write = 0; e.ifid_write = 0; e.flush = 1; e.kill = 0;
        end else if (redir) begin
            e.pc_write = 1; e.ifid_write = 1; e.flush = 1; e.kill = 1;
        end else begin
            e.pc_write = !ex_busy; e.ifid_write = !ex_busy; e.flush = 0; e.kill = 0;
        end
        e.pipe_write = !ex_busy;
        issue = id_valid && id_long && !ds && !redir && !ex_busy;
        if (done_valid) begin
            m_pend[done_rd] = 1'b0;
            m_busy[done_ch] = 1'b0;
        end
        if (issue) begin
            m_busy[id_ch] = 1'b1;
            if (id_rd != 0) m_pend[id_rd] = 1'b1;
        end
        if (m_cnt >= int'(STALL_LIMIT)) m_alarm = 1'b1;
        m_cnt = ds ? ((m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt) : 0;
        for (int r = 0; r < 32; r++) e.pending[r] = m_pend[r];
        for (int c = 0; c < 2; c++) e.ch_busy[c] = m_busy[c];
        e.cnt   = 3'(m_cnt);
        e.alarm = m_alarm;
        q.push_back(e);
    endtask

    task automatic set_idle();
        rs1 = '0; rs2 = '0; id_rd = '0; ex_rd = '0; mem_rd = '0; done_rd = '0;
        id_valid = 0; id_long = 0; id_ch = '0; id_branch = 0; id_jalr = 0; id_jump = 0;
        ex_regwrite = 0; ex_memread = 0; mem_memread = 0; ex_br_taken = 0; ex_busy = 0;
        done_valid = 0; done_ch = '0;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        set_idle();
    endtask

    task automatic issue_long(input int rd, input int ch);
        id_valid = 1; id_long = 1; id_rd = 5'(rd); id_ch = 1'(ch);
        rs1 = 5'd1; rs2 = 5'd2;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_pc_write"}, 32'(pc_write), 32'd1);
        chk({tag, "_ifid_write"}, 32'(ifid_write), 32'd1);
        chk({tag, "_flush"}, 32'(flush), 32'd0);
        chk({tag, "_kill"}, 32'(kill), 32'd0);
        chk({tag, "_idex_write"}, 32'(idex_write), 32'd1);
        chk({tag, "_pending"}, pending, 32'd0);
        chk({tag, "_ch_busy"}, 32'(ch_busy), 32'd0);
        chk({tag, "_stall_cnt"}, 32'(stall_cnt), 32'd0);
        chk({tag, "_alarm"}, 32'(stall_alarm), 32'd0);
    endtask

    // Mid-run reset once the monitor has drained the queue
    task automatic do_reset();
        @(posedge clk);
        #3;
        set_idle();
        rst_n = 1'b0;
        #1;
        check_reset_state("mid_reset");
        model_reset();
        @(posedge clk);
        #2;
        check_reset_state("reset_held");
        rst_n = 1'b1;
    endtask

    // Monitor: compare combinational outputs before the edge and state just after it
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("pc_write", 32'(pc_write), 32'(e.pc_write));
                chk("ifid_write", 32'(ifid_write), 32'(e.ifid_write));
                chk("flush", 32'(flush), 32'(e.flush));
                chk("kill", 32'(kill), 32'(e.kill));
                chk("idex_write", 32'(idex_write), 32'(e.pipe_write));
                chk("exmem_write", 32'(exmem_write), 32'(e.pipe_write));
                chk("memwb_write", 32'(memwb_write), 32'(e.pipe_write));
                @(posedge clk);
                #1;
                chk("pending", pending, e.pending);
                chk("ch_busy", 32'(ch_busy), 32'(e.ch_busy));
                chk("stall_cnt", 32'(stall_cnt), 32'(e.cnt));
                chk("stall_alarm", 32'(stall_alarm), 32'(e.alarm));
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rst_n = 1'b0;
        set_idle();
        model_reset();
        #2;
        check_reset_state("reset");
        #10;
        rst_n = 1'b1;

        // Long op to x5 on ch1, dependent ADD stalls until completion releases it same-cycle
        tick(); issue_long(5, 1); model_push();
        for (int i = 0; i < 11; i++) begin
            tick();
            id_valid = 1; rs1 = 5'd5; rs2 = 5'd6; id_rd = 5'd8;
            if (i == 10) begin
                done_valid = 1; done_ch = 1'b1; done_rd = 5'd5;
            end
            model_push();
        end
        tick(); model_push();

        // Load in EX then MEM feeding a branch, then released
        tick(); id_valid = 1; id_branch = 1; rs1 = 5'd3; rs2 = 5'd4;
        ex_memread = 1; ex_rd = 5'd3; model_push();
        tick(); id_valid = 1; id_branch = 1; rs1 = 5'd3; rs2 = 5'd4;
        mem_memread = 1; mem_rd = 5'd3; model_push();
        tick(); id_valid = 1; id_branch = 1; rs1 = 5'd3; rs2 = 5'd4; model_push();

        // Stall and taken branch together: stall has priority
        tick(); id_valid = 1; rs1 = 5'd3; ex_memread = 1; ex_rd = 5'd3; ex_br_taken = 1;
        model_push();
        tick(); ex_br_taken = 1; model_push();

        // JALR: rs1 dependency stalls, rs2-only match does not
        tick(); id_valid = 1; id_jalr = 1; rs1 = 5'd12; ex_regwrite = 1; ex_rd = 5'd12;
        model_push();
        tick(); id_valid = 1; id_jalr = 1; rs1 = 5'd1; rs2 = 5'd12; ex_regwrite = 1;
        ex_rd = 5'd12; model_push();

        // Completion accepted while EX is frozen
        tick(); issue_long(7, 0); model_push();
        tick(); ex_busy = 1; done_valid = 1; done_ch = 1'b0; done_rd = 5'd7; model_push();

        // Long op to x0 marks the channel only, then back-to-back on ch0 via bypass
        tick(); issue_long(0, 0); model_push();
        tick(); issue_long(10, 0); done_valid = 1; done_ch = 1'b0; done_rd = 5'd0; model_push();
        tick(); issue_long(11, 0); done_valid = 1; done_ch = 1'b0; done_rd = 5'd10; model_push();
        tick(); issue_long(13, 0); model_push();
        tick(); done_valid = 1; done_ch = 1'b0; done_rd = 5'd11; model_push();

        do_reset();

        for (int i = 0; i < 2500; i++) begin
            tick();
            rs1         = 5'($urandom_range(0, 7));
            rs2         = 5'($urandom_range(0, 7));
            id_rd       = 5'($urandom_range(0, 7));
            ex_rd       = 5'($urandom_range(0, 7));
            mem_rd      = 5'($urandom_range(0, 7));
            done_rd     = 5'($urandom_range(0, 7));
            id_ch       = 1'($urandom_range(0, 1));
            done_ch     = 1'($urandom_range(0, 1));
            id_valid    = ($urandom_range(0, 99) < 85);
            id_long     = ($urandom_range(0, 99) < 35);
            id_branch   = ($urandom_range(0, 99) < 15);
            id_jalr     = ($urandom_range(0, 99) < 10);
            id_jump     = ($urandom_range(0, 99) < 8);
            ex_regwrite = ($urandom_range(0, 99) < 40);
            ex_memread  = ($urandom_range(0, 99) < 15);
            mem_memread = ($urandom_range(0, 99) < 15);
            ex_br_taken = ($urandom_range(0, 99) < 8);
            ex_busy     = ($urandom_range(0, 99) < 12);
            done_valid  = ($urandom_range(0, 99) < 30);
            model_push();
            if (i == 1200) do_reset();
        end

        @(posedge clk);
        #3;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
